// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between pipe_ctrl and the pipeline stages.
// The controller side uses the master modport and the pipeline side uses the slave modport.
interface pipe_ctrl_if #(
  parameter int ADDR_W  = 32,
  parameter int STALL_W = 6
);
  logic               stallreq_if_i;
  logic               stallreq_id_i;
  logic               stallreq_mem_i;
  logic               branch_flag_i;
  logic [ADDR_W-1:0]  branch_address_i;
  logic               if_ready_i;
  logic [STALL_W-1:0] stall_o;
  logic               flush_id_o;
  logic               redirect_valid_o;
  logic [ADDR_W-1:0]  redirect_addr_o;

  modport master (
    input  stallreq_if_i, stallreq_id_i, stallreq_mem_i,
    input  branch_flag_i, branch_address_i, if_ready_i,
    output stall_o, flush_id_o, redirect_valid_o, redirect_addr_o
  );

  modport slave (
    output stallreq_if_i, stallreq_id_i, stallreq_mem_i,
    output branch_flag_i, branch_address_i, if_ready_i,
    input  stall_o, flush_id_o, redirect_valid_o, redirect_addr_o
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline controller for the 5-stage core: stall merging, branch redirect hold and IF/ID squash.
// Optional performance counters are enabled by defining PIPE_CTRL_PERF_EN.
module pipe_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int STALL_W = 6
) (
  input  logic         clk,
  input  logic         rst,
  pipe_ctrl_if.master  bus
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0]  perf_stall_cycles_o,
  output logic [31:0]  perf_flush_cnt_o,
  output logic [31:0]  perf_redirect_wait_o
`endif
);

  typedef enum logic [0:0] {IDLE, PEND} state_t;

  state_t             state;
  logic [ADDR_W-1:0]  held_addr;
  logic [STALL_W-1:0] base_stall;
  logic [STALL_W-1:0] stall;
  logic               accept;
  logic               consume;

  // MEM outranks ID outranks IF; a busy MEM freezes everything upstream of WB.
  always_comb begin
    base_stall = '0;
    if (bus.stallreq_mem_i)
      base_stall = STALL_W'(6'b011111);
    else if (bus.stallreq_id_i)
      base_stall = STALL_W'(6'b000111);
    else if (bus.stallreq_if_i)
      base_stall = STALL_W'(6'b000011);
  end

  // While a redirect is pending the PC must not advance on the sequential path.
  always_comb begin
    stall = base_stall;
    if (state == PEND)
      stall[0] = 1'b1;
  end

  assign accept  = bus.branch_flag_i && !stall[2] && (state == IDLE);
  assign consume = (state == PEND) && bus.if_ready_i && !bus.stallreq_mem_i;

  assign bus.stall_o          = stall;
  assign bus.flush_id_o       = accept || (state == PEND);
  assign bus.redirect_valid_o = (state == PEND);
  assign bus.redirect_addr_o  = (state == PEND) ? held_addr : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      held_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state     <= PEND;
            held_addr <= bus.branch_address_i;
          end
        end
        PEND: begin
          if (consume)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cycles_o  <= '0;
      perf_flush_cnt_o     <= '0;
      perf_redirect_wait_o <= '0;
    end else begin
      if ((stall != '0) && (perf_stall_cycles_o != 32'hFFFF_FFFF))
        perf_stall_cycles_o <= perf_stall_cycles_o + 32'd1;
      if (accept && (perf_flush_cnt_o != 32'hFFFF_FFFF))
        perf_flush_cnt_o <= perf_flush_cnt_o + 32'd1;
      if ((state == PEND) && !consume && (perf_redirect_wait_o != 32'hFFFF_FFFF))
        perf_redirect_wait_o <= perf_redirect_wait_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus random traffic against a pending-redirect model.
// Define PIPE_CTRL_PERF_EN to also check the performance counters.
module tb_pipe_ctrl;

  logic clk;
  logic rst;

  pipe_ctrl_if #(.ADDR_W(32), .STALL_W(6)) bus ();

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall_cycles_o;
  logic [31:0] perf_flush_cnt_o;
  logic [31:0] perf_redirect_wait_o;
`endif

  pipe_ctrl #(.ADDR_W(32), .STALL_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .perf_stall_cycles_o  (perf_stall_cycles_o),
    .perf_flush_cnt_o     (perf_flush_cnt_o),
    .perf_redirect_wait_o (perf_redirect_wait_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: is a redirect outstanding, and to where.
  bit          m_pend = 0;
  logic [31:0] m_addr = '0;
  logic        obs_rv;
`ifdef PIPE_CTRL_PERF_EN
  longint m_stall_cnt = 0;
  longint m_flush_cnt = 0;
  longint m_wait_cnt  = 0;
`endif

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs, check outputs mid-cycle, then advance the model at the edge.
  task automatic applyStimulus(input logic r, input logic sif, input logic sid, input logic smem,
                               input logic bf, input logic [31:0] ba, input logic rdy);
    logic [5:0]  e_stall;
    logic        e_accept;
    logic [31:0] e_addr;
    rst                  = r;
    bus.stallreq_if_i    = sif;
    bus.stallreq_id_i    = sid;
    bus.stallreq_mem_i   = smem;
    bus.branch_flag_i    = bf;
    bus.branch_address_i = ba;
    bus.if_ready_i       = rdy;
    @(negedge clk);
    e_stall  = smem ? 6'h1F : sid ? 6'h07 : sif ? 6'h03 : 6'h00;
    if (m_pend) e_stall = e_stall | 6'h01;
    e_accept = bf && !m_pend && !smem && !sid;
    e_addr   = m_pend ? m_addr : 32'h0;
    obs_rv   = bus.redirect_valid_o;
    checkOutput("stall",          32'(bus.stall_o),         32'(e_stall));
    checkOutput("flush_id",       32'(bus.flush_id_o),      32'(e_accept || m_pend));
    checkOutput("redirect_valid", 32'(bus.redirect_valid_o), 32'(m_pend));
    checkOutput("redirect_addr",  bus.redirect_addr_o,      e_addr);
`ifdef PIPE_CTRL_PERF_EN
    checkOutput("perf_stall",  perf_stall_cycles_o,  32'(m_stall_cnt));
    checkOutput("perf_flush",  perf_flush_cnt_o,     32'(m_flush_cnt));
    checkOutput("perf_wait",   perf_redirect_wait_o, 32'(m_wait_cnt));
`endif
    @(posedge clk);
`ifdef PIPE_CTRL_PERF_EN
    if (r) begin
      m_stall_cnt = 0; m_flush_cnt = 0; m_wait_cnt = 0;
    end else begin
      if (e_stall != 0 && m_stall_cnt < 64'hFFFF_FFFF) m_stall_cnt++;
      if (e_accept && m_flush_cnt < 64'hFFFF_FFFF) m_flush_cnt++;
      if (m_pend && !(rdy && !smem) && m_wait_cnt < 64'hFFFF_FFFF) m_wait_cnt++;
    end
`endif
    if (r) begin
      m_pend = 0;
      m_addr = '0;
    end else if (e_accept) begin
      m_pend = 1;
      m_addr = ba;
    end else if (m_pend && rdy && !smem) begin
      m_pend = 0;
    end
    #1;
  endtask

  int rv_count;

  initial begin
    rst = 1'b1;
    bus.stallreq_if_i = 0; bus.stallreq_id_i = 0; bus.stallreq_mem_i = 0;
    bus.branch_flag_i = 0; bus.branch_address_i = '0; bus.if_ready_i = 0;
    repeat (2) @(posedge clk);
    #1;
    $display("[TB] reset released, starting directed scenarios");

    // Reset state and stall priority
    applyStimulus(0, 0, 0, 0, 0, 32'h0, 0);
    applyStimulus(0, 1, 0, 0, 0, 32'h0, 0);
    applyStimulus(0, 1, 1, 0, 0, 32'h0, 0);
    applyStimulus(0, 1, 1, 1, 0, 32'h0, 0);
    applyStimulus(0, 0, 0, 0, 0, 32'h0, 0);

    // Basic redirect with IF ready immediately
    applyStimulus(0, 0, 0, 0, 1, 32'h0000_1040, 1);
    applyStimulus(0, 0, 0, 0, 0, 32'h0, 1);
    applyStimulus(0, 0, 0, 0, 0, 32'h0, 1);

    // Blocked handshake with an ignored second branch
    rv_count = 0;
    applyStimulus(0, 0, 0, 0, 1, 32'h200, 0);
    applyStimulus(0, 0, 0, 0, 0, 32'h0, 0);   rv_count += int'(obs_rv);
    applyStimulus(0, 0, 0, 0, 1, 32'h300, 0); rv_count += int'(obs_rv);
    applyStimulus(0, 0, 0, 0, 0, 32'h0, 0);   rv_count += int'(obs_rv);
    applyStimulus(0, 0, 0, 1, 0, 32'h0, 1);   rv_count += int'(obs_rv);
    applyStimulus(0, 0, 0, 0, 0, 32'h0, 1);   rv_count += int'(obs_rv);
    applyStimulus(0, 0, 0, 0, 0, 32'h0, 0);   rv_count += int'(obs_rv);
    checkOutput("pend_cycles", 32'(rv_count), 32'd5);

    // Load-use hazard blocks the branch, then it is re-presented
    applyStimulus(0, 0, 1, 0, 1, 32'h0000_4444, 1);
    applyStimulus(0, 0, 0, 0, 1, 32'h0000_4444, 0);
    applyStimulus(0, 0, 0, 0, 0, 32'h0, 1);
    applyStimulus(0, 0, 0, 0, 0, 32'h0, 0);

    // Reset while a redirect is pending
    applyStimulus(0, 0, 0, 0, 1, 32'h0000_8888, 0);
    applyStimulus(1, 0, 0, 0, 0, 32'h0, 0);
    applyStimulus(0, 0, 0, 0, 0, 32'h0, 0);
    applyStimulus(0, 0, 0, 0, 0, 32'h0, 0);

`ifdef PIPE_CTRL_PERF_EN
    // Counter scenario: 3 stall cycles, then a branch that waits 2 cycles
    applyStimulus(1, 0, 0, 0, 0, 32'h0, 0);
    applyStimulus(0, 1, 0, 0, 0, 32'h0, 0);
    applyStimulus(0, 1, 0, 0, 0, 32'h0, 0);
    applyStimulus(0, 1, 0, 0, 0, 32'h0, 0);
    applyStimulus(0, 0, 0, 0, 1, 32'h0000_0A00, 0);
    applyStimulus(0, 0, 0, 0, 0, 32'h0, 0);
    applyStimulus(0, 0, 0, 0, 0, 32'h0, 0);
    applyStimulus(0, 0, 0, 0, 0, 32'h0, 1);
    @(negedge clk);
    checkOutput("perf_stall_total", perf_stall_cycles_o,  32'd6);
    checkOutput("perf_flush_total", perf_flush_cnt_o,     32'd1);
    checkOutput("perf_wait_total",  perf_redirect_wait_o, 32'd2);
    @(posedge clk);
    #1;
`endif

    $display("[TB] starting random traffic");
    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(63) == 0),
                    ($urandom_range(3) == 0),
                    ($urandom_range(4) == 0),
                    ($urandom_range(4) == 0),
                    ($urandom_range(2) == 0),
                    $urandom,
                    ($urandom_range(1) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central pipeline controller for the 5-stage RV32I core (PC, IF, ID, EX, MEM, WB).
- Merges stall requests from IF, ID (load-use) and MEM into one per-stage stall vector.
- Captures branch/jump redirects from ID and holds them until IF accepts them.
- Drives the IF/ID squash signal so wrong-path instructions become bubbles.

Parameters:
- ADDR_W, 32, width of the redirect address.
- STALL_W, 6, stall vector width; bit0=PC, 1=IF, 2=ID, 3=EX, 4=MEM, 5=WB.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- stallreq_if_i  in  1  IF busy (fetch not complete).
- stallreq_id_i  in  1  ID load-use hazard.
- stallreq_mem_i  in  1  MEM busy (load/store multi-cycle).
- branch_flag_i  in  1  ID resolved a taken branch or jump this cycle.
- branch_address_i  in  ADDR_W  target address for branch_flag_i.
- if_ready_i  in  1  IF accepts a redirect this cycle.
- stall_o  out  STALL_W  per-stage hold; 1 = stage register keeps its value.
- flush_id_o  out  1  load a bubble into the IF/ID register at the next edge.
- redirect_valid_o  out  1  redirect pending toward IF.
- redirect_addr_o  out  ADDR_W  pending redirect target.

Behaviour:
- Reset: at a clock edge with rst=1, state:=IDLE and the pending address register:=0.
- Outputs while in IDLE with no requests: stall_o=0, flush_id_o=0, redirect_valid_o=0, redirect_addr_o=0.
- rst mid-operation drops any pending redirect. No redirect_valid_o is asserted after reset.
- Base stall vector, combinational, priority MEM > ID > IF:
  - stallreq_mem_i=1: 6'b011111.
  - else stallreq_id_i=1: 6'b000111.
  - else stallreq_if_i=1: 6'b000011.
  - else 6'b000000.
- Branch acceptance: a branch is accepted in a cycle only when branch_flag_i=1, stall_o[2]=0 and state=IDLE.
- branch_flag_i under any other condition is ignored. The held address is never overwritten.
- State machine:
  - IDLE: on an accepted branch, flush_id_o=1 in the same cycle, combinationally. At the edge, capture branch_address_i and go to PEND.
  - PEND: redirect_valid_o=1, redirect_addr_o=held address, flush_id_o=1. stall_o = base OR 6'b000001, so the PC does not advance on the sequential path.
  - PEND, handshake: when redirect_valid_o=1, if_ready_i=1 and stallreq_mem_i=0, the redirect is consumed at that edge and state goes to IDLE.
  - PEND, otherwise: stay in PEND.
- Redirect latency: redirect_valid_o rises exactly 1 cycle after the accepting cycle. Minimum branch penalty is 2 bubbles.
- stallreq_mem_i=1 during PEND blocks the handshake even if if_ready_i=1. This keeps IF/MEM memory-port ordering.
- IDLE: redirect_addr_o=0 and flush_id_o reflects only an accepted branch.
- Simultaneous branch_flag_i and stallreq_id_i: the stall wins and the branch is not accepted. ID re-presents the branch once the stall clears.
- No internal counters overflow in the base build.

Optional Feature:
- Macro PIPE_CTRL_PERF_EN.
- When defined, add outputs perf_stall_cycles_o[31:0], perf_flush_cnt_o[31:0] and perf_redirect_wait_o[31:0]:
  - perf_stall_cycles_o: increments each cycle stall_o!=0.
  - perf_flush_cnt_o: increments per accepted branch.
  - perf_redirect_wait_o: increments each PEND cycle not consumed.
- All three saturate at 32'hFFFFFFFF and reset to 0 on rst.
- When undefined, the ports and counters are absent. Base behaviour is identical in both builds.

Test Plan:
- Stall priority: rst then stallreq_if_i=1 -> stall_o=6'b000011. Add stallreq_id_i=1 -> 6'b000111. Add stallreq_mem_i=1 -> 6'b011111. Release all -> 6'b000000.
- Basic redirect: branch_flag_i=1, branch_address_i=32'h0000_1040, if_ready_i=1.
  - Cycle N: flush_id_o=1.
  - Cycle N+1: redirect_valid_o=1, redirect_addr_o=32'h1040, stall_o[0]=1.
  - Cycle N+2: IDLE, redirect_valid_o=0.
- Blocked handshake: branch to 32'h200, if_ready_i=0 for 3 cycles, then 1 while stallreq_mem_i=1 for 1 cycle, then released.
  - redirect_valid_o stays high 5 cycles.
  - Address stays 32'h200.
  - A second branch_flag_i pulse (target 32'h300) during PEND leaves the address at 32'h200.
- Hazard vs branch: branch_flag_i=1 with stallreq_id_i=1 -> flush_id_o=0, no PEND. Next cycle, stall cleared and branch held -> accepted normally.
- Reset mid-PEND: assert rst while redirect_valid_o=1 -> next cycle all outputs 0. With rst released and no stimulus, redirect_valid_o stays 0.
- PIPE_CTRL_PERF_EN build: 3 stall cycles plus 1 branch with 2 wait cycles -> perf_stall_cycles_o=6 (3 stall + 3 PEND cycles with stall_o[0]=1), perf_flush_cnt_o=1, perf_redirect_wait_o=2.
